// File: rtl/pam_sample_ctrl.sv
// pam_sample_ctrl: paces the sine-LUT index with a programmable step divider.
// It pulses sample_pulse once per carrier period (each lut_idx wrap to 0).
// A burst ends after n_samples periods; n_samples == 0 runs until stop.
// Optional macro PAM_PHASE_ALIGN_EN: a stop in RUN drains to the next wrap,
// so the carrier always ends phase-aligned. Undefined: stop aborts at once.
module pam_sample_ctrl #(
   parameter int DIV_W = 8,
   parameter int CNT_W = 8,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [DIV_W-1:0] div,
   input  logic [CNT_W-1:0] n_samples,
   output logic [IDX_W-1:0] lut_idx,
   output logic             lut_en,
   output logic             sample_pulse,
   output logic [CNT_W-1:0] sample_cnt,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
`ifdef PAM_PHASE_ALIGN_EN
      S_DRAIN = 2'd3,
`endif
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   logic [DIV_W-1:0] r_div;
   logic [CNT_W-1:0] r_n;
   logic [DIV_W-1:0] r_div_cnt;
   logic [IDX_W-1:0] r_lut_idx;
   logic             r_lut_en;
   logic             r_sample_pulse;
   logic [CNT_W-1:0] r_sample_cnt;
   logic             r_busy;
   logic             r_done;

   state_t           w_state_next;
   logic [DIV_W-1:0] w_div_next;
   logic [CNT_W-1:0] w_n_next;
   logic [DIV_W-1:0] w_div_cnt_next;
   logic [IDX_W-1:0] w_idx_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_lut_en_next;
   logic             w_pulse_next;
   logic             w_busy_next;
   logic             w_done_next;

   // One stepping cycle: the divider expires, the index advances and a
   // 15->0 transition completes a carrier period.
   logic             w_step;
   logic             w_wrap;
   logic             w_last;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [DIV_W-1:0] w_adv_div_cnt;
   logic [IDX_W-1:0] w_adv_idx;
   logic [CNT_W-1:0] w_adv_cnt;

   assign w_step        = (r_div_cnt == r_div);
   assign w_wrap        = w_step && (r_lut_idx == {IDX_W{1'b1}});
   assign w_cnt_inc     = r_sample_cnt + 1'b1;
   // Terminating wrap: the sample just counted completes a finite burst.
   assign w_last        = w_wrap && (r_n != '0) && (w_cnt_inc == r_n);
   assign w_adv_div_cnt = w_step ? '0 : r_div_cnt + 1'b1;
   assign w_adv_idx     = w_step ? r_lut_idx + 1'b1 : r_lut_idx;
   assign w_adv_cnt     = w_wrap ? w_cnt_inc : r_sample_cnt;

   // Next-state and next-output decode; all outputs leave through registers.
   always_comb begin
      w_state_next   = r_state;
      w_div_next     = r_div;
      w_n_next       = r_n;
      w_div_cnt_next = r_div_cnt;
      w_idx_next     = r_lut_idx;
      w_cnt_next     = r_sample_cnt;
      w_lut_en_next  = 1'b0;
      w_pulse_next   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // stop has priority over a simultaneous start
            if (start && !stop) begin
               w_state_next   = S_RUN;
               w_div_next     = div;
               w_n_next       = n_samples;
               w_div_cnt_next = '0;
               w_idx_next     = '0;
               w_cnt_next     = '0;
            end
         end
         S_RUN: begin
            if (stop && !w_last) begin
`ifdef PAM_PHASE_ALIGN_EN
               // keep stepping; finish at the next wrap
               w_div_cnt_next = w_adv_div_cnt;
               w_idx_next     = w_adv_idx;
               w_cnt_next     = w_adv_cnt;
               w_lut_en_next  = w_step;
               w_pulse_next   = w_wrap;
               w_state_next   = S_DRAIN;
`else
               // immediate abort: index frozen, no step this cycle
               w_state_next   = S_DONE;
`endif
            end else begin
               w_div_cnt_next = w_adv_div_cnt;
               w_idx_next     = w_adv_idx;
               w_cnt_next     = w_adv_cnt;
               w_lut_en_next  = w_step;
               w_pulse_next   = w_wrap;
               if (w_last) begin
                  w_state_next = S_DONE;
               end
            end
         end
`ifdef PAM_PHASE_ALIGN_EN
         S_DRAIN: begin
            w_div_cnt_next = w_adv_div_cnt;
            w_idx_next     = w_adv_idx;
            w_cnt_next     = w_adv_cnt;
            w_lut_en_next  = w_step;
            w_pulse_next   = w_wrap;
            if (w_wrap) begin
               w_state_next = S_DONE;
            end
         end
`endif
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
`ifdef PAM_PHASE_ALIGN_EN
      w_busy_next = (w_state_next == S_RUN) || (w_state_next == S_DRAIN);
`else
      w_busy_next = (w_state_next == S_RUN);
`endif
      w_done_next = (w_state_next == S_DONE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         r_div          <= '0;
         r_n            <= '0;
         r_div_cnt      <= '0;
         r_lut_idx      <= '0;
         r_lut_en       <= 1'b0;
         r_sample_pulse <= 1'b0;
         r_sample_cnt   <= '0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_div          <= w_div_next;
         r_n            <= w_n_next;
         r_div_cnt      <= w_div_cnt_next;
         r_lut_idx      <= w_idx_next;
         r_lut_en       <= w_lut_en_next;
         r_sample_pulse <= w_pulse_next;
         r_sample_cnt   <= w_cnt_next;
         r_busy         <= w_busy_next;
         r_done         <= w_done_next;
      end
   end

   assign lut_idx      = r_lut_idx;
   assign lut_en       = r_lut_en;
   assign sample_pulse = r_sample_pulse;
   assign sample_cnt   = r_sample_cnt;
   assign busy         = r_busy;
   assign done         = r_done;

endmodule

// File: tb/tb_pam_sample_ctrl.sv
// Testbench for pam_sample_ctrl: table-driven bursts, hand-written corner
// sequences and a randomized phase, all checked cycle by cycle against an
// arithmetic reference model (elapsed cycles -> steps -> index/samples).
module tb_pam_sample_ctrl;
   localparam int DIV_W = 8;
   localparam int CNT_W = 8;
   localparam int IDX_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic [DIV_W-1:0] div = '0;
   logic [CNT_W-1:0] n_samples = '0;
   logic [IDX_W-1:0] lut_idx;
   logic             lut_en;
   logic             sample_pulse;
   logic [CNT_W-1:0] sample_cnt;
   logic             busy;
   logic             done;

   always #5 clk = ~clk;

   pam_sample_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .div(div),
      .n_samples(n_samples), .lut_idx(lut_idx), .lut_en(lut_en),
      .sample_pulse(sample_pulse), .sample_cnt(sample_cnt), .busy(busy),
      .done(done)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   bit m_busy, m_indone, m_drain;
   int m_t, m_d, m_n, m_idx, m_cnt;
   bit m_en, m_pulse, m_done;

   // per-burst tallies
   int busy_cycles, pulses, dones;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model advance for one clock edge using the currently driven inputs.
   // A burst is described by t = edges since start: a step happens when t is
   // a multiple of (div+1), the index is steps mod 16, samples = steps / 16.
   task automatic model_edge();
      bit step, wrap, term;
      int s;
      m_en = 0; m_pulse = 0; m_done = 0;
      if (!rst) begin
         m_busy = 0; m_indone = 0; m_drain = 0;
         m_idx = 0; m_cnt = 0; m_t = 0;
      end else if (m_indone) begin
         m_indone = 0;
      end else if (!m_busy) begin
         if (start && !stop) begin
            m_busy = 1; m_t = 0; m_d = int'(div); m_n = int'(n_samples);
            m_idx = 0; m_cnt = 0; m_drain = 0;
         end
      end else begin
         m_t++;
         step = (m_t % (m_d + 1)) == 0;
         s    = m_t / (m_d + 1);
         wrap = step && ((s % 16) == 0);
         term = wrap && (m_drain || (m_n != 0 && ((s / 16) % 256) == m_n));
`ifndef PAM_PHASE_ALIGN_EN
         if (stop && !term) begin
            m_busy = 0; m_done = 1; m_indone = 1;
         end else begin
`else
         begin
            if (stop && !term) m_drain = 1;
`endif
            if (step) begin
               m_en  = 1;
               m_idx = s % 16;
            end
            if (wrap) begin
               m_pulse = 1;
               m_cnt   = (s / 16) % 256;
            end
            if (term) begin
               m_busy = 0; m_done = 1; m_indone = 1; m_drain = 0;
            end
         end
      end
   endtask

   // One clock: update model, take the edge, sample #1 later and compare.
   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      chk("lut_idx", int'(lut_idx), m_idx);
      chk("lut_en", int'(lut_en), int'(m_en));
      chk("sample_pulse", int'(sample_pulse), int'(m_pulse));
      chk("sample_cnt", int'(sample_cnt), m_cnt);
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      if (busy) busy_cycles++;
      if (sample_pulse) pulses++;
      if (done) dones++;
   endtask

   task automatic clear_tally();
      busy_cycles = 0; pulses = 0; dones = 0;
   endtask

   typedef struct {
      int d;
      int n;
      bit poke_start;
      int busy_exp;
      int pulses_exp;
      int cnt_exp;
      int idx_exp;
   } vec_t;

   vec_t tbl[5];

   initial begin
      bit timed_out;
      tbl[0] = '{d: 0, n: 2, poke_start: 1'b0, busy_exp: 32,  pulses_exp: 2, cnt_exp: 2, idx_exp: 0};
      tbl[1] = '{d: 3, n: 1, poke_start: 1'b0, busy_exp: 64,  pulses_exp: 1, cnt_exp: 1, idx_exp: 0};
      tbl[2] = '{d: 1, n: 3, poke_start: 1'b1, busy_exp: 96,  pulses_exp: 3, cnt_exp: 3, idx_exp: 0};
      tbl[3] = '{d: 2, n: 1, poke_start: 1'b1, busy_exp: 48,  pulses_exp: 1, cnt_exp: 1, idx_exp: 0};
      tbl[4] = '{d: 0, n: 5, poke_start: 1'b0, busy_exp: 80,  pulses_exp: 5, cnt_exp: 5, idx_exp: 0};

      // reset
      rst = 1'b0;
      tick(); tick();
      chk("reset_busy", int'(busy), 0);
      chk("reset_idx", int'(lut_idx), 0);
      rst = 1'b1;
      tick();

      // table-driven bursts
      for (int v = 0; v < 5; v++) begin
         clear_tally();
         div = DIV_W'(tbl[v].d); n_samples = CNT_W'(tbl[v].n);
         start = 1'b1; tick(); start = 1'b0;
         timed_out = 1'b1;
         for (int c = 0; c < 20000; c++) begin
            start = (tbl[v].poke_start && c == 5);
            tick();
            start = 1'b0;
            if (done) begin timed_out = 1'b0; break; end
         end
         chk("burst_timeout", int'(timed_out), 0);
         chk("burst_busy_cycles", busy_cycles, tbl[v].busy_exp);
         chk("burst_pulses", pulses, tbl[v].pulses_exp);
         chk("burst_cnt", int'(sample_cnt), tbl[v].cnt_exp);
         chk("burst_idx", int'(lut_idx), tbl[v].idx_exp);
         chk("burst_done_at_pulse", int'(sample_pulse), 1);
         tick();
         chk("burst_single_done", dones, 1);
         $display("burst div=%0d n=%0d busy_cycles=%0d pulses=%0d cnt=%0d",
                  tbl[v].d, tbl[v].n, busy_cycles, pulses, sample_cnt);
      end

      // abort at lut_idx == 5
      clear_tally();
      div = 0; n_samples = 0;
      start = 1'b1; tick(); start = 1'b0;
      timed_out = 1'b1;
      for (int c = 0; c < 100; c++) begin
         if (lut_idx == 5) begin timed_out = 1'b0; break; end
         tick();
      end
      chk("abort_reach_idx5", int'(timed_out), 0);
      stop = 1'b1; tick(); stop = 1'b0;
`ifndef PAM_PHASE_ALIGN_EN
      chk("abort_done", int'(done), 1);
      chk("abort_idx", int'(lut_idx), 5);
      chk("abort_cnt", int'(sample_cnt), 0);
      chk("abort_no_en", int'(lut_en), 0);
`else
      timed_out = 1'b1;
      for (int c = 0; c < 100; c++) begin
         if (done) begin timed_out = 1'b0; break; end
         tick();
      end
      chk("drain_timeout", int'(timed_out), 0);
      chk("drain_pulse", int'(sample_pulse), 1);
      chk("drain_idx", int'(lut_idx), 0);
      chk("drain_cnt", int'(sample_cnt), 1);
`endif
      tick();
      $display("abort idx=%0d cnt=%0d dones=%0d", lut_idx, sample_cnt, dones);

      // start and stop together in IDLE: stop wins
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      chk("prio_stay_idle", int'(busy), 0);
      tick();
      $display("priority start+stop busy=%0d", busy);

      // reset mid-burst
      clear_tally();
      div = 1; n_samples = 3;
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 0; c < 20; c++) tick();
      rst = 1'b0; tick(); tick();
      chk("rst_mid_idx", int'(lut_idx), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_cnt", int'(sample_cnt), 0);
      chk("rst_mid_no_done", dones, 0);
      rst = 1'b1; tick();
      $display("mid-burst reset busy=%0d idx=%0d", busy, lut_idx);

      // continuous mode: sample_cnt runs past its modulus
      clear_tally();
      div = 0; n_samples = 0;
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 0; c < 258 * 16; c++) tick();
      chk("cont_cnt_wrapped", int'(sample_cnt), 2);
      chk("cont_no_done", dones, 0);
      stop = 1'b1; tick(); stop = 1'b0;
      timed_out = 1'b1;
      for (int c = 0; c < 100; c++) begin
         if (dones != 0) begin timed_out = 1'b0; break; end
         tick();
      end
      chk("cont_stop_done", int'(timed_out), 0);
      tick();
      $display("continuous pulses=%0d cnt=%0d", pulses, sample_cnt);

      // randomized stimulus against the model
      for (int c = 0; c < 3000; c++) begin
         start     = ($urandom % 8) == 0;
         stop      = ($urandom % 64) == 0;
         rst       = ($urandom % 700) != 0;
         div       = DIV_W'($urandom_range(0, 3));
         n_samples = CNT_W'($urandom_range(0, 3));
         tick();
      end
      start = 1'b0; stop = 1'b0; rst = 1'b1;
      $display("random phase complete");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pam_sample_ctrl.md
# pam_sample_ctrl

Sequencer for the PAM carrier datapath. It drives the 4-bit index and step enable of the 16-entry sine lookup and paces it with a programmable clock divider. It raises one sample strobe per full carrier period and stops after a programmed burst of samples or on request. It sits between the system control logic and the sine generator / PAM modulator.

## Interface
Parameters:
- DIV_W, 8, width of the step divider (cycles per LUT step = div+1)
- CNT_W, 8, width of burst length and sample counter
- IDX_W, 4, LUT index width (LUT depth = 2^IDX_W)

Ports:
- clk  in  1  single clock; all logic on posedge clk
- rst  in  1  reset: synchronous, active-low (rst==0 at a posedge resets the block)
- start  in  1  begin a burst; sampled only in IDLE
- stop  in  1  abort request; sampled in RUN (and IDLE, see priority)
- div  in  DIV_W  step period minus one; latched on accepted start
- n_samples  in  CNT_W  samples per burst; 0 = continuous until stop; latched on accepted start
- lut_idx  out  IDX_W  index presented to sine LUT
- lut_en  out  1  one-cycle pulse: lut_idx just advanced
- sample_pulse  out  1  one-cycle pulse: carrier period completed (lut_idx wrapped to 0)
- sample_cnt  out  CNT_W  samples taken in current/last burst
- busy  out  1  high in RUN (and DRAIN)
- done  out  1  one-cycle pulse on burst completion or abort

## Operation
- States: IDLE, RUN, DRAIN (only with macro), DONE.
- IDLE: start=1 and stop=0 -> RUN; latch div, n_samples; clear div_cnt, lut_idx, sample_cnt. start and stop both high -> stay IDLE (stop wins).
- RUN: div_cnt increments each cycle; when div_cnt==div_latched: div_cnt->0, lut_idx->lut_idx+1 (mod 2^IDX_W, 15->0 wraps), lut_en=1.
- Wrap (lut_idx 15->0): sample_pulse=1, sample_cnt+1 (mod 2^CNT_W).
- Burst end: wrap that makes sample_cnt == n_samples (n_samples!=0) -> DONE on the same edge.
- n_samples==0: sample_cnt wraps freely; only stop ends the burst.
- stop in RUN: -> DONE (macro off) or DRAIN (macro on). If stop coincides with the terminating wrap, normal completion; single done.
- DONE: done=1 for exactly one cycle, busy=0; -> IDLE. lut_idx and sample_cnt hold until next accepted start.
- start while busy or in DONE: ignored.
- All outputs registered.

## Timing
- Reset values: lut_idx=0, lut_en=0, sample_pulse=0, sample_cnt=0, busy=0, done=0, state IDLE, div_cnt=0.
- Start accepted at edge k: busy=1 from cycle k+1.
- First lut_en: div+1 cycles after busy rises. Then every div+1 cycles; div=0 -> every cycle.
- Carrier period = 16*(div+1) cycles; sample_pulse at that rate, coincident with lut_en and lut_idx==0.
- Terminating wrap edge: lut_en=1, sample_pulse=1, done=1, busy=0 all in the same cycle.
- Abort (macro off): done one cycle after the edge sampling stop; no lut_en in that cycle.
- Reset mid-burst: all state returns to reset values at that edge; no done pulse.

## Configuration
- PAM_PHASE_ALIGN_EN defined: stop in RUN enters DRAIN. Stepping continues at the same rate until the next wrap to lut_idx=0. That wrap issues lut_en, sample_pulse and counts the sample, then goes to DONE on the same edge (done in that cycle). busy stays 1 in DRAIN, and stop/start are ignored there. Stop when lut_idx==0 still drains a full period.
- Not defined: DRAIN absent. Stop aborts immediately with lut_idx left at its current value.

## Test plan
- Reset: hold rst=0 two cycles mid-RUN -> all outputs 0, IDLE; no done.
- Burst: div=0, n_samples=2, start -> lut_en every cycle from cycle after busy rises. sample_pulse twice, 16 cycles apart. done coincides with second pulse; sample_cnt=2; busy high exactly 32 cycles.
- Divider: div=3, n_samples=1 -> lut_en every 4 cycles, lut_idx 1..15,0. Single done 64 cycles after busy rises.
- Abort (macro off): div=0, n_samples=0, stop when lut_idx=5 -> done next cycle, lut_idx stays 5, sample_cnt=0. With PAM_PHASE_ALIGN_EN: steps continue to 0, done with sample_pulse, sample_cnt=1.
- Priority: start+stop together in IDLE -> stays IDLE. Start pulsed during RUN -> ignored, counters unaffected.
- Continuous wrap: CNT_W=2, n_samples=0, div=0 -> sample_cnt 1,2,3,0,1 over five periods; no done until stop.
